// File: rtl/ct_f_spsram_access_ctrl.sv
// Initiator-side access controller for a single-port SRAM macro.
// Turns a valid/ready request stream into CEN/GWEN/WEN/A/D pin activity,
// returns read data through a 2-entry response buffer and zero-fills the
// array after reset when INIT_EN is set.
//
// Handshake semantics (both channels): a transfer happens on a rising CLK
// edge where valid and ready are both high; valid never depends on ready.
// req_rdy may depend combinationally on req_wr and rsp_rdy.
module ct_f_spsram_access_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 144,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   sweep_q;
    logic                    rd_inflight_q;
    logic                    init_done_q;
    logic [DATA_WIDTH-1:0]   buf_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              cnt_q;

    logic                    is_run;
    logic                    pop;
    logic                    push;
    logic                    acc;
    logic [2:0]              occ;

    // Handshake and occupancy: reads are admitted only if the buffer can
    // still absorb every read already in flight plus this one.
    always_comb begin
        is_run    = (state_q == ST_RUN);
        rsp_vld   = !RST && (cnt_q != 2'd0);
        rsp_rdata = RST ? '0 : buf_q[rd_ptr_q];
        init_done = !RST && init_done_q;
        pop       = rsp_vld && rsp_rdy;
        push      = rd_inflight_q;
        occ       = {1'b0, cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
        req_rdy   = !RST && is_run && (req_wr || (occ < 3'd2));
        acc       = req_vld && req_rdy;
    end

    // Next state and SRAM pin drive; pins are idle whenever RST is high.
    always_comb begin
        state_d = state_q;
        CEN     = 1'b1;
        GWEN    = 1'b1;
        WEN     = '1;
        A       = '0;
        D       = '0;
        case (state_q)
            ST_INIT: begin
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
                if (!RST) begin
                    CEN  = 1'b0;
                    GWEN = 1'b0;
                    WEN  = '0;
                    A    = sweep_q;
                end
            end
            ST_RUN: begin
                if (!RST) begin
                    A = req_addr;
                    D = req_wdata;
                    if (acc) begin
                        CEN = 1'b0;
                        if (req_wr) begin
                            GWEN = 1'b0;
                            WEN  = ~req_bmask;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State register, zero-fill sweep counter and registered init_done.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= INIT_EN ? ST_INIT : ST_RUN;
            sweep_q     <= '0;
            init_done_q <= !INIT_EN;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == ST_RUN);
            if (state_q == ST_INIT && sweep_q != LAST_ADDR) begin
                sweep_q <= sweep_q + 1'b1;
            end
        end
    end

    // Read in flight: Q is valid during the cycle after the read edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= acc && !req_wr;
        end
    end

    // Two-entry in-order response buffer; push and pop may coincide.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= Q;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_access_ctrl.sv
// Bench for ct_f_spsram_access_ctrl: behavioural SRAM macro, reference
// memory image and an expected-response queue with due cycles.
module tb_ct_f_spsram_access_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 144;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_bmask;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_f_spsram_access_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_EN    (1'b1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_bmask (req_bmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .A         (sram_a),
        .CEN       (sram_cen),
        .GWEN      (sram_gwen),
        .WEN       (sram_wen),
        .D         (sram_d),
        .Q         (sram_q)
    );

    // ---------------- behavioural SRAM macro ----------------
    logic [DW-1:0] sram_mem [DEPTH];

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= sram_mem[sram_a];
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            exp_t[$];
    int            cyc;
    int            init_cnt;
    bit            run;
    bit            last_acc;
    int            checks;
    int            errors;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            w = (w << 32) | DW'($urandom);
        end
        return w;
    endfunction

    task automatic chk_b(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        logic          exp_vld;
        logic          exp_rdy;
        logic          acc;
        logic          pop;
        logic [DW-1:0] cur;
        @(negedge clk);
        acc = 1'b0;
        pop = 1'b0;
        if (rst) begin
            chk_b("rst_cen", sram_cen, 1'b1);
            chk_b("rst_gwen", sram_gwen, 1'b1);
            chk_w("rst_wen", sram_wen, '1);
            chk_w("rst_a", DW'(sram_a), '0);
            chk_w("rst_d", sram_d, '0);
            chk_b("rst_req_rdy", req_rdy, 1'b0);
            chk_b("rst_rsp_vld", rsp_vld, 1'b0);
            chk_w("rst_rsp_rdata", rsp_rdata, '0);
            chk_b("rst_init_done", init_done, 1'b0);
        end else if (!run) begin
            chk_b("init_cen", sram_cen, 1'b0);
            chk_b("init_gwen", sram_gwen, 1'b0);
            chk_w("init_wen", sram_wen, '0);
            chk_w("init_d", sram_d, '0);
            chk_w("init_a", DW'(sram_a), DW'(init_cnt));
            chk_b("init_req_rdy", req_rdy, 1'b0);
            chk_b("init_rsp_vld", rsp_vld, 1'b0);
            chk_b("init_done_low", init_done, 1'b0);
        end else begin
            exp_vld = (exp_q.size() > 0) && (exp_t[0] <= cyc);
            chk_b("rsp_vld", rsp_vld, exp_vld);
            if (exp_vld) begin
                chk_w("rsp_rdata", rsp_rdata, exp_q[0]);
            end
            pop     = exp_vld && rsp_rdy;
            exp_rdy = req_wr || ((exp_q.size() - (pop ? 1 : 0)) < 2);
            chk_b("req_rdy", req_rdy, exp_rdy);
            acc = req_vld && exp_rdy;
            chk_b("init_done_high", init_done, 1'b1);
            chk_b("run_cen", sram_cen, !acc);
            chk_b("run_gwen", sram_gwen, !(acc && req_wr));
            chk_w("run_wen", sram_wen, (acc && req_wr) ? ~req_bmask : '1);
            chk_w("run_a", DW'(sram_a), DW'(req_addr));
            chk_w("run_d", sram_d, req_wdata);
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_t.delete();
            init_cnt = 0;
            run      = 1'b0;
        end else if (!run) begin
            init_cnt++;
            if (init_cnt == DEPTH) begin
                run = 1'b1;
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
            end
            if (acc) begin
                if (req_wr) begin
                    cur = ref_mem[req_addr];
                    ref_mem[req_addr] = (cur & ~req_bmask) | (req_wdata & req_bmask);
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    exp_t.push_back(cyc + 2);
                end
            end
        end
        cyc++;
        last_acc = acc;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] bmask,
                          output int n);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_bmask = bmask;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        chk_b("req_accept_timeout", last_acc, 1'b1);
        req_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        chk_w("drain_timeout", DW'(exp_q.size()), '0);
        cycle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int            n;
        logic [DW-1:0] bm;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        init_cnt  = 0;
        run       = 1'b0;
        last_acc  = 1'b0;
        rst       = 1'b1;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_bmask = '0;
        rsp_rdy   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = rand_word();
            ref_mem[i]  = '0;
        end

        // Zero-fill sweep, with request traffic that must be held off.
        cycle();
        cycle();
        rst = 1'b0;
        repeat (DEPTH) begin
            req_vld  = 1'($urandom_range(0, 1));
            req_wr   = 1'($urandom_range(0, 1));
            req_addr = AW'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        req_vld = 1'b0;
        req_wr  = 1'b0;
        cycle();

        // Write then immediate read of the same address.
        rsp_rdy = 1'b1;
        do_req(1'b1, AW'(5), {9{16'hA5A5}}, '1, n);
        do_req(1'b0, AW'(5), '0, '0, n);
        drain();

        // Masked write over an all-ones word.
        bm = {16'h00FF, 112'h0, 16'h0000};
        do_req(1'b1, AW'(9), '1, '1, n);
        do_req(1'b1, AW'(9), '0, bm, n);
        do_req(1'b0, AW'(9), '0, '0, n);
        drain();

        // Backpressure: two reads fill the buffer, third is held off.
        rsp_rdy = 1'b0;
        do_req(1'b0, AW'(5), '0, '0, n);
        chk_w("bp_read1_cycles", DW'(n), DW'(1));
        do_req(1'b0, AW'(9), '0, '0, n);
        chk_w("bp_read2_cycles", DW'(n), DW'(1));
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = AW'(20);
        repeat (3) cycle();
        do_req(1'b1, AW'(20), rand_word(), '1, n);
        chk_w("bp_write_cycles", DW'(n), DW'(1));
        rsp_rdy = 1'b1;
        do_req(1'b0, AW'(20), '0, '0, n);
        do_req(1'b0, AW'(5), '0, '0, n);
        drain();

        // Streaming reads: one accept per cycle.
        rsp_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, AW'(i), '0, '0, n);
            chk_w("stream_accept_cycles", DW'(n), DW'(1));
        end
        drain();

        // Randomized traffic over a small address window.
        repeat (400) begin
            req_vld   = 1'($urandom_range(0, 3) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = rand_word();
            req_bmask = ($urandom_range(0, 1) != 0) ? '1 : rand_word();
            rsp_rdy   = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        // Reset in RUN with reads outstanding; then reset mid-sweep.
        rsp_rdy = 1'b0;
        do_req(1'b0, AW'(1), '0, '0, n);
        do_req(1'b0, AW'(2), '0, '0, n);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (1000) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (DEPTH) cycle();
        cycle();

        // Array is zero again after the completed sweep.
        rsp_rdy = 1'b1;
        do_req(1'b0, AW'(9), '0, '0, n);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, AW'($urandom_range(0, DEPTH - 1)), '0, '0, n);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_f_spsram_access_ctrl.md
Name: ct_f_spsram_access_ctrl

Overview:
Initiator-side controller for the single-port SRAM macro (active-low CEN/GWEN/WEN, Q one cycle after a read).
- Converts a valid/ready request stream (read or bit-masked write) into SRAM pin activity.
- Returns read data through a 2-entry response buffer with valid/ready backpressure.
- After reset, zero-initialises the whole array before accepting requests.
- Sits between a cache/buffer owner and the SRAM wrapper instance.

Parameters:
ADDR_WIDTH, 11, SRAM address width; the array has 2^ADDR_WIDTH words.
DATA_WIDTH, 144, SRAM word width.
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = usable immediately.

Ports:
CLK  in  1  clock; all logic on posedge.
RST  in  1  synchronous, active-high reset.
req_vld  in  1  request valid.
req_rdy  out  1  request ready; transfer on req_vld&req_rdy.
req_wr  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  word address.
req_wdata  in  DATA_WIDTH  write data.
req_bmask  in  DATA_WIDTH  active-high per-bit write enable.
rsp_vld  out  1  read response valid.
rsp_rdy  in  1  response ready; pop on rsp_vld&rsp_rdy.
rsp_rdata  out  DATA_WIDTH  read data, head of response buffer.
init_done  out  1  high once the controller is in RUN.
A  out  ADDR_WIDTH  SRAM address.
CEN  out  1  SRAM chip enable, active-low.
GWEN  out  1  SRAM global write enable, active-low.
WEN  out  DATA_WIDTH  SRAM per-bit write enable, active-low.
D  out  DATA_WIDTH  SRAM write data.
Q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read edge.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- While RST is high, all outputs are forced as follows: CEN=1, GWEN=1, WEN=all ones, A=0, D=0, req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0. The response buffer, in-flight flag and sweep counter are all cleared.
- FSM states: INIT and RUN.
  - Reset enters INIT if INIT_EN=1, otherwise RUN.
  - INIT: drives one write per cycle with CEN=0, GWEN=0, WEN=0, D=0, A=sweep counter, counting 0 up to 2^ADDR_WIDTH-1. req_rdy=0 throughout.
  - After the write to the last address, the next cycle is RUN. Total INIT duration is exactly 2^ADDR_WIDTH cycles. No wrap.
  - RUN: init_done=1, registered and asserted from the first RUN cycle. Stays in RUN until RST.
- SRAM drive in RUN is combinational from the handshake.
  - Idle cycle (no accepted request): CEN=1, GWEN=1, WEN=all ones; A=req_addr, D=req_wdata.
  - Accepted write: CEN=0, GWEN=0, WEN=~req_bmask, D=req_wdata. No response is generated.
  - A write with req_bmask=0 is still issued; array contents are unchanged.
  - Accepted read: CEN=0, GWEN=1, WEN=all ones. Sets rd_inflight for the next cycle.
- Read capture:
  - While rd_inflight=1, Q is pushed into the response buffer at the end of that cycle.
  - rsp_vld rises 2 cycles after the read accept edge.
- Response buffer: 2-entry FIFO, in order; rsp_rdata = head entry. Push and pop in the same cycle are both allowed.
- Ready rule: req_rdy = RUN && (req_wr || occ < 2), where occ = fifo_cnt + rd_inflight - (rsp_vld&rsp_rdy).
  - This yields sustained one read per cycle while rsp_rdy=1.
  - The buffer never overflows, and Q is never dropped.
  - req_rdy may depend combinationally on req_wr and rsp_rdy.
- Ordering: a read accepted the cycle after a write to the same address returns the new data. Write-then-read needs no extra spacing.
- Reset mid-operation (INIT or RUN): buffered and in-flight reads are discarded, and the sweep restarts from address 0.

Test Plan:
1. INIT_EN=1: release RST. Check 2048 consecutive cycles with CEN=0, GWEN=0, WEN=0, D=0, A=0..2047, with req_rdy=0. Then init_done=1 and req_rdy=1 on the next cycle.
2. In RUN: write addr 5 with data 0x..A5A5 and full mask, then read addr 5 the following cycle. Check rsp_vld two cycles after the read accept, with rsp_rdata=0x..A5A5.
3. Masked write: bmask=0x00FF_..._0000 over a word pre-written with all ones, data=0. Readback shows only the masked bits cleared; WEN equals ~bmask during the write cycle.
4. Read backpressure: issue 4 back-to-back reads with rsp_rdy=0. Exactly 2 are accepted, then req_rdy=0 while req_wr=0. A write is still accepted. Raise rsp_rdy: all 4 responses return in order, with no loss.
5. Streaming: 16 reads with rsp_rdy=1. One accept per cycle and one response per cycle after 2 cycles of latency.
6. Assert RST at sweep address 1000, hold 1 cycle, then release. The sweep restarts at A=0, and 2048 further cycles elapse before init_done=1.
